// File: rtl/core_int_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | core_int_pkg : shared types and default vectors for core_int_ctrl |
// | Revision     : 1.0                                                |
// +------------------------------------------------------------------+
package core_int_pkg;

    typedef enum logic [1:0] {
        KIND_NONE = 2'd0,
        KIND_IRQ  = 2'd1,
        KIND_NMI  = 2'd2,
        KIND_RES  = 2'd3
    } int_kind_type;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_SERVICE = 1'b1
    } state_type;

    localparam logic [15:0] c_nmi_vector = 16'hFFFA;
    localparam logic [15:0] c_res_vector = 16'hFFFC;
    localparam logic [15:0] c_irq_vector = 16'hFFFE;

    // A single-channel build still needs a one-bit source index.
    function automatic int src_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/core_int_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | core_int_ctrl_if : core <-> interrupt controller signal bundle    |
// | Revision         : 1.0                                            |
// +------------------------------------------------------------------+
interface core_int_ctrl_if #(
    parameter int IRQ_CHANNELS = 4
);
    import core_int_pkg::*;

    localparam int SRC_W = src_width(IRQ_CHANNELS);

    logic                    I_enable;
    logic                    I_nmi;
    logic [IRQ_CHANNELS-1:0] I_irq;
    logic [IRQ_CHANNELS-1:0] I_irq_mask;
    logic [IRQ_CHANNELS-1:0] I_irq_edge;
    logic [IRQ_CHANNELS-1:0] I_irq_clear;
    logic                    I_i_flag;
    logic                    I_poll;
    logic                    I_ack;
    logic                    O_take;
    int_kind_type            O_kind;
    logic [15:0]             O_vector;
    logic [SRC_W-1:0]        O_irq_src;
    logic [IRQ_CHANNELS-1:0] O_pending;

    modport master (
        output I_enable, I_nmi, I_irq, I_irq_mask, I_irq_edge, I_irq_clear,
               I_i_flag, I_poll, I_ack,
        input  O_take, O_kind, O_vector, O_irq_src, O_pending
    );

    modport slave (
        input  I_enable, I_nmi, I_irq, I_irq_mask, I_irq_edge, I_irq_clear,
               I_i_flag, I_poll, I_ack,
        output O_take, O_kind, O_vector, O_irq_src, O_pending
    );

endinterface
`default_nettype wire

// File: rtl/core_edge_latch.sv
`default_nettype none
// +------------------------------------------------------------------+
// | core_edge_latch : falling-edge detector, set wins over clear      |
// | Revision        : 1.0                                             |
// +------------------------------------------------------------------+
module core_edge_latch (
    input  wire logic I_clock,
    input  wire logic I_reset,
    input  wire logic I_in,
    input  wire logic I_clear,
    output logic      O_latch
);

    logic r_prev;
    logic r_latch;

    // The previous sample tracks the line through reset so a line already
    // low when reset lifts is not mistaken for a fresh edge.
    always_ff @(posedge I_clock) begin
        r_prev <= I_in;
        if (I_reset) begin
            r_latch <= 1'b0;
        end else if (r_prev && !I_in) begin
            r_latch <= 1'b1;
        end else if (I_clear) begin
            r_latch <= 1'b0;
        end
    end

    assign O_latch = r_latch;

endmodule
`default_nettype wire

// File: rtl/core_int_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | core_int_ctrl : N-channel IRQ / NMI / RESET arbiter for the core  |
// | Build option  : CORE_INT_VECTOR_TABLE_EN (per-channel IRQ vectors)|
// | Revision      : 1.0                                               |
// +------------------------------------------------------------------+
module core_int_ctrl
    import core_int_pkg::*;
#(
    parameter int          IRQ_CHANNELS   = 4,
    parameter logic [15:0] NMI_VECTOR     = c_nmi_vector,
    parameter logic [15:0] RES_VECTOR     = c_res_vector,
    parameter logic [15:0] IRQ_VECTOR     = c_irq_vector
`ifdef CORE_INT_VECTOR_TABLE_EN
    ,
    parameter logic [15:0] IRQ_TABLE_BASE = 16'hFFE0
`endif
) (
    input  wire logic       I_clock,
    input  wire logic       I_reset,
    core_int_ctrl_if.slave  bus
);

    localparam int SRC_W = src_width(IRQ_CHANNELS);

    logic [IRQ_CHANNELS-1:0] w_irq_latch;
    logic [IRQ_CHANNELS-1:0] w_irq_pending;
    logic [IRQ_CHANNELS-1:0] w_pending_masked;
    logic                    w_nmi_pend;
    logic                    w_nmi_ack;
    logic                    w_irq_req;
    logic [SRC_W-1:0]        w_irq_src;
    logic [15:0]             w_irq_vector;

    state_type               r_state;
    logic                    r_res_pend;
    logic                    r_take;
    int_kind_type            r_kind;
    logic [15:0]             r_vector;
    logic [SRC_W-1:0]        r_irq_src;

    for (genvar g = 0; g < IRQ_CHANNELS; g++) begin : g_irq_latch
        core_edge_latch u_irq_latch (
            .I_clock (I_clock),
            .I_reset (I_reset),
            .I_in    (bus.I_irq[g]),
            .I_clear (bus.I_irq_clear[g]),
            .O_latch (w_irq_latch[g])
        );
    end

    // The NMI latch doubles as nmi_pend; a coincident new edge beats the ack.
    core_edge_latch u_nmi_latch (
        .I_clock (I_clock),
        .I_reset (I_reset),
        .I_in    (bus.I_nmi),
        .I_clear (w_nmi_ack),
        .O_latch (w_nmi_pend)
    );

    assign w_nmi_ack = (r_state == ST_SERVICE) && bus.I_enable && bus.I_ack
                       && (r_kind == KIND_NMI);

    assign w_irq_pending    = (bus.I_irq_edge & w_irq_latch) | (~bus.I_irq_edge & ~bus.I_irq);
    assign w_pending_masked = w_irq_pending & bus.I_irq_mask;
    assign w_irq_req        = (|w_pending_masked) && !bus.I_i_flag;

    // Lowest-index pending channel wins.
    always_comb begin
        w_irq_src = '0;
        for (int i = IRQ_CHANNELS - 1; i >= 0; i--) begin
            if (w_pending_masked[i]) begin
                w_irq_src = SRC_W'(i);
            end
        end
    end

`ifdef CORE_INT_VECTOR_TABLE_EN
    assign w_irq_vector = IRQ_TABLE_BASE + (16'(w_irq_src) << 1);
`else
    assign w_irq_vector = IRQ_VECTOR;
`endif

    always_ff @(posedge I_clock) begin
        if (I_reset) begin
            r_state    <= ST_IDLE;
            r_res_pend <= 1'b1;
            r_take     <= 1'b0;
            r_kind     <= KIND_NONE;
            r_vector   <= IRQ_VECTOR;
            r_irq_src  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.I_enable && bus.I_poll) begin
                        if (r_res_pend) begin
                            r_state   <= ST_SERVICE;
                            r_take    <= 1'b1;
                            r_kind    <= KIND_RES;
                            r_vector  <= RES_VECTOR;
                            r_irq_src <= '0;
                        end else if (w_nmi_pend) begin
                            r_state   <= ST_SERVICE;
                            r_take    <= 1'b1;
                            r_kind    <= KIND_NMI;
                            r_vector  <= NMI_VECTOR;
                            r_irq_src <= '0;
                        end else if (w_irq_req) begin
                            r_state   <= ST_SERVICE;
                            r_take    <= 1'b1;
                            r_kind    <= KIND_IRQ;
                            r_vector  <= w_irq_vector;
                            r_irq_src <= w_irq_src;
                        end
                    end
                end
                ST_SERVICE: begin
                    // IRQ sources are cleared at their origin, never here.
                    if (bus.I_enable && bus.I_ack) begin
                        if (r_kind == KIND_RES) begin
                            r_res_pend <= 1'b0;
                        end
                        r_state  <= ST_IDLE;
                        r_take   <= 1'b0;
                        r_kind   <= KIND_NONE;
                        r_vector <= IRQ_VECTOR;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.O_take    = r_take;
    assign bus.O_kind    = r_kind;
    assign bus.O_vector  = r_vector;
    assign bus.O_irq_src = r_irq_src;
    assign bus.O_pending = w_pending_masked;

endmodule
`default_nettype wire

// File: tb/tb_core_int_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_core_int_ctrl : scoreboard bench with a behavioural reference  |
// | Revision         : 1.0                                            |
// +------------------------------------------------------------------+
module tb_core_int_ctrl;
    import core_int_pkg::*;

    localparam int          N     = 4;
    localparam logic [15:0] C_NMI = 16'hFFFA;
    localparam logic [15:0] C_RES = 16'hFFFC;
    localparam logic [15:0] C_IRQ = 16'hFFFE;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    core_int_ctrl_if #(.IRQ_CHANNELS(N)) bus ();

    core_int_ctrl #(.IRQ_CHANNELS(N)) dut (
        .I_clock (clk),
        .I_reset (rst),
        .bus     (bus)
    );

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] vector;
        logic [7:0]  src;
    } exp_t;

    exp_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // Reference state: what is owed to the core, in plain terms.
    logic         m_res  = 1'b1;
    logic         m_nmi  = 1'b0;
    logic         m_serv = 1'b0;
    int           m_kind = 0;
    logic [N-1:0] m_lat  = '0;
    logic         m_prev_nmi = 1'b1;
    logic [N-1:0] m_prev_irq = '1;
    logic         prev_take  = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    function automatic logic [N-1:0] model_pending();
        logic [N-1:0] p;
        for (int i = 0; i < N; i++)
            p[i] = bus.I_irq_mask[i] && (bus.I_irq_edge[i] ? m_lat[i] : !bus.I_irq[i]);
        return p;
    endfunction

    task automatic accept(input int kind, input logic [15:0] vec, input int src);
        exp_t e;
        e.kind = 2'(kind); e.vector = vec; e.src = 8'(src);
        q.push_back(e);
        m_serv = 1'b1;
        m_kind = kind;
    endtask

    // Called once per rising edge with the inputs the DUT just sampled.
    task automatic model_update();
        logic [N-1:0] pend;
        logic         nmi_fall;
        logic         nmi_done;
        logic [N-1:0] irq_fall;
        logic [15:0]  v;
        int           src;
        if (rst) begin
            m_res = 1'b1; m_nmi = 1'b0; m_lat = '0; m_serv = 1'b0; m_kind = 0;
            m_prev_nmi = bus.I_nmi; m_prev_irq = bus.I_irq;
            return;
        end
        nmi_fall = m_prev_nmi && !bus.I_nmi;
        irq_fall = m_prev_irq & ~bus.I_irq;
        pend     = model_pending();
        nmi_done = 1'b0;
        if (!m_serv) begin
            if (bus.I_enable && bus.I_poll) begin
                if (m_res) accept(3, C_RES, 0);
                else if (m_nmi) accept(2, C_NMI, 0);
                else if (pend != 0 && !bus.I_i_flag) begin
                    src = 0;
                    while (!pend[src]) src++;
                    v = C_IRQ;
`ifdef CORE_INT_VECTOR_TABLE_EN
                    v = 16'hFFE0 + 16'(2 * src);
`endif
                    accept(1, v, src);
                end
            end
        end else if (bus.I_enable && bus.I_ack) begin
            if (m_kind == 3) m_res = 1'b0;
            if (m_kind == 2) nmi_done = 1'b1;
            m_serv = 1'b0;
            m_kind = 0;
        end
        if (nmi_fall) m_nmi = 1'b1;
        else if (nmi_done) m_nmi = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (irq_fall[i]) m_lat[i] = 1'b1;
            else if (bus.I_irq_clear[i]) m_lat[i] = 1'b0;
        end
        m_prev_nmi = bus.I_nmi;
        m_prev_irq = bus.I_irq;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic cleanup();
        bus.I_enable = 1'b0; bus.I_poll = 1'b0; bus.I_ack = 1'b0;
        bus.I_irq_clear = '1;
        tick();
        bus.I_irq_clear = '0;
    endtask

    // Monitor: per-cycle state checks plus scoreboard pop on each new take.
    always @(negedge clk) begin
        exp_t e;
        chk("take", 32'(bus.O_take), 32'(m_serv));
        chk("kind", 32'(bus.O_kind), 32'(m_kind));
        chk("pending", 32'(bus.O_pending), 32'(model_pending()));
        if (bus.O_take && !prev_take) begin
            if (q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_take: kind %0d with no accepted request", bus.O_kind);
            end else begin
                e = q.pop_front();
                chk("sb_kind", 32'(bus.O_kind), 32'(e.kind));
                chk("sb_vector", 32'(bus.O_vector), 32'(e.vector));
                if (e.kind == 2'd1) chk("sb_irq_src", 32'(bus.O_irq_src), 32'(e.src));
            end
        end
        prev_take = bus.O_take;
    end

    initial begin
        logic [15:0] exp_v2;
        exp_v2 = C_IRQ;
`ifdef CORE_INT_VECTOR_TABLE_EN
        exp_v2 = 16'hFFE4;
`endif
        bus.I_enable = 1'b0; bus.I_nmi = 1'b1; bus.I_irq = '1;
        bus.I_irq_mask = '0; bus.I_irq_edge = '0; bus.I_irq_clear = '0;
        bus.I_i_flag = 1'b1; bus.I_poll = 1'b0; bus.I_ack = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_take", 32'(bus.O_take), 0);
        chk("rst_kind", 32'(bus.O_kind), 0);
        chk("rst_vector", 32'(bus.O_vector), 32'(C_IRQ));
        chk("rst_src", 32'(bus.O_irq_src), 0);
        chk("rst_pending", 32'(bus.O_pending), 0);

        // Pending reset taken on the first poll, then retired by ack.
        bus.I_enable = 1'b1; bus.I_poll = 1'b1;
        tick();
        chk("res_take", 32'(bus.O_take), 1);
        chk("res_kind", 32'(bus.O_kind), 3);
        chk("res_vector", 32'(bus.O_vector), 32'(C_RES));
        bus.I_poll = 1'b0; bus.I_ack = 1'b1;
        tick();
        chk("res_ack", 32'(bus.O_take), 0);
        bus.I_ack = 1'b0; bus.I_poll = 1'b1;
        repeat (2) tick();
        chk("res_once", 32'(bus.O_take), 0);
        cleanup();

        // Edge-mode channel 2.
        bus.I_irq_edge = 4'b0100; bus.I_irq_mask = 4'b0100; bus.I_i_flag = 1'b0;
        tick();
        bus.I_irq[2] = 1'b0;
        tick();
        bus.I_irq[2] = 1'b1;
        tick();
        chk("edge_pending", 32'(bus.O_pending), 32'h4);
        bus.I_enable = 1'b1; bus.I_poll = 1'b1;
        tick();
        chk("edge_take", 32'(bus.O_take), 1);
        chk("edge_kind", 32'(bus.O_kind), 1);
        chk("edge_src", 32'(bus.O_irq_src), 2);
        chk("edge_vector", 32'(bus.O_vector), 32'(exp_v2));
        bus.I_poll = 1'b0; bus.I_ack = 1'b1;
        tick();
        cleanup();

        // Level channel 0 blocked by the I flag.
        bus.I_irq_edge = '0; bus.I_irq_mask = 4'b0001; bus.I_i_flag = 1'b1;
        bus.I_irq[0] = 1'b0; bus.I_enable = 1'b1; bus.I_poll = 1'b1;
        repeat (3) tick();
        chk("iflag_block", 32'(bus.O_take), 0);
        bus.I_i_flag = 1'b0;
        tick();
        chk("iflag_take", 32'(bus.O_take), 1);
        chk("iflag_src", 32'(bus.O_irq_src), 0);
        bus.I_poll = 1'b0; bus.I_ack = 1'b1; bus.I_irq[0] = 1'b1;
        tick();
        cleanup();

        // NMI beats a simultaneously pending IRQ channel 1.
        bus.I_irq_mask = 4'b0010; bus.I_irq_edge = 4'b0010;
        bus.I_nmi = 1'b0; bus.I_irq[1] = 1'b0;
        repeat (2) tick();
        bus.I_nmi = 1'b1; bus.I_irq[1] = 1'b1; bus.I_enable = 1'b1; bus.I_poll = 1'b1;
        tick();
        chk("nmi_kind", 32'(bus.O_kind), 2);
        chk("nmi_vector", 32'(bus.O_vector), 32'(C_NMI));
        bus.I_poll = 1'b0; bus.I_ack = 1'b1;
        tick();
        chk("nmi_ack", 32'(bus.O_take), 0);
        bus.I_ack = 1'b0; bus.I_poll = 1'b1;
        tick();
        chk("after_nmi_kind", 32'(bus.O_kind), 1);
        chk("after_nmi_src", 32'(bus.O_irq_src), 1);
        bus.I_poll = 1'b0; bus.I_ack = 1'b1;
        tick();
        cleanup();

        // New NMI edge coincident with the NMI ack.
        bus.I_irq_mask = '0; bus.I_nmi = 1'b0;
        tick();
        bus.I_nmi = 1'b1; bus.I_enable = 1'b1; bus.I_poll = 1'b1;
        tick();
        chk("nmi2_kind", 32'(bus.O_kind), 2);
        bus.I_poll = 1'b0; bus.I_ack = 1'b1; bus.I_nmi = 1'b0;
        tick();
        chk("nmi2_ack", 32'(bus.O_take), 0);
        bus.I_ack = 1'b0; bus.I_nmi = 1'b1; bus.I_poll = 1'b1;
        tick();
        chk("nmi2_retake", 32'(bus.O_take), 1);
        chk("nmi2_rekind", 32'(bus.O_kind), 2);
        bus.I_poll = 1'b0; bus.I_ack = 1'b1;
        tick();
        cleanup();

        // Reset in the middle of an IRQ service.
        bus.I_irq_mask = 4'b0001; bus.I_irq[0] = 1'b0; bus.I_i_flag = 1'b0;
        bus.I_enable = 1'b1; bus.I_poll = 1'b1;
        tick();
        chk("abort_irq", 32'(bus.O_kind), 1);
        bus.I_poll = 1'b0; rst = 1'b1;
        tick();
        chk("abort_take", 32'(bus.O_take), 0);
        rst = 1'b0; bus.I_irq[0] = 1'b1; bus.I_poll = 1'b1;
        tick();
        chk("abort_res_kind", 32'(bus.O_kind), 3);
        chk("abort_res_vector", 32'(bus.O_vector), 32'(C_RES));
        bus.I_poll = 1'b0; bus.I_ack = 1'b1;
        tick();
        cleanup();

        // Randomised traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            bus.I_enable = 1'($urandom_range(0, 1));
            bus.I_poll   = ($urandom_range(0, 2) == 0);
            bus.I_ack    = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 19) == 0) bus.I_nmi = ~bus.I_nmi;
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 9) == 0) bus.I_irq[i] = ~bus.I_irq[i];
            if ($urandom_range(0, 49) == 0) bus.I_irq_mask = N'($urandom);
            if ($urandom_range(0, 49) == 0) bus.I_irq_edge = N'($urandom);
            bus.I_irq_clear = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
            if ($urandom_range(0, 9) == 0) bus.I_i_flag = ~bus.I_i_flag;
            tick();
        end

        rst = 1'b0; bus.I_enable = 1'b1; bus.I_poll = 1'b0; bus.I_ack = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/core_int_ctrl.md
Name: core_int_ctrl

Overview:
- Parametrised interrupt controller for the 2A03-class core.
- Replaces the core's fixed single-IRQ/NMI/reset logic with N maskable IRQ channels, each selectable as level- or edge-triggered.
- Arbitrates interrupt requests at instruction boundaries, holds the accepted request until the core acknowledges its vector fetch, and supplies the vector address.
- Sits beside the core; its state updates on the core's cycle strobe.

Parameters:
- IRQ_CHANNELS, 4: number of IRQ sources (1..8).
- NMI_VECTOR, 16'hFFFA: NMI vector low-byte address.
- RES_VECTOR, 16'hFFFC: reset vector low-byte address.
- IRQ_VECTOR, 16'hFFFE: shared IRQ/BRK vector low-byte address.
- IRQ_TABLE_BASE, 16'hFFE0: per-channel vector table base (used only with the optional feature).

Ports:
- I_clock  in  1  system clock.
- I_reset  in  1  reset, synchronous, active-high.
- I_enable  in  1  core cycle strobe (falling-phase edge); gates arbitration and acknowledge.
- I_nmi  in  1  NMI, active-low, falling-edge triggered.
- I_irq  in  IRQ_CHANNELS  IRQ lines, active-low.
- I_irq_mask  in  IRQ_CHANNELS  1 = channel enabled.
- I_irq_edge  in  IRQ_CHANNELS  1 = falling-edge latched; 0 = level.
- I_irq_clear  in  IRQ_CHANNELS  1 clears that channel's edge latch.
- I_i_flag  in  1  core P.I flag.
- I_poll  in  1  core is at T0 (instruction boundary).
- I_ack  in  1  core has fetched the vector high byte.
- O_take  out  1  forced break in progress.
- O_kind  out  2  00 none/BRK, 01 IRQ, 10 NMI, 11 RESET.
- O_vector  out  16  vector low-byte address.
- O_irq_src  out  $clog2(IRQ_CHANNELS) (min 1)  accepted IRQ channel.
- O_pending  out  IRQ_CHANNELS  masked pending IRQs.

Behaviour:
- Reset values (cycle after I_reset sampled high):
  - res_pend = 1; nmi_pend = 0; all edge latches = 0.
  - State IDLE.
  - O_take = 0, O_kind = 00, O_vector = IRQ_VECTOR, O_irq_src = 0, O_pending = 0.
- Reset mid-service aborts the service and returns to reset values.
- Edge detection:
  - Samples I_nmi and I_irq every clock, regardless of I_enable.
  - A 1→0 transition sets the latch.
  - If set and clear occur in the same clock, set wins.
- Pending computation:
  - Edge-mode channel: pending = latch.
  - Level-mode channel: pending = ~I_irq.
  - O_pending = pending & I_irq_mask, combinational.
- State machine, IDLE → SERVICE:
  - Evaluated on a clock where I_enable & I_poll are high.
  - Priority: res_pend → RESET; else nmi_pend → NMI; else (|O_pending & ~I_i_flag) → IRQ.
  - O_irq_src = lowest-index pending channel.
  - O_kind, O_irq_src and O_vector are registered at this point; O_take = 1 on the next clock.
  - If nothing qualifies, stay IDLE.
- State machine, SERVICE → IDLE:
  - On I_enable & I_ack.
  - RESET clears res_pend; NMI clears nmi_pend.
  - IRQ clears nothing: an edge latch is cleared only via I_irq_clear; a level source is cleared at its origin.
  - O_take drops to 0 and O_kind to 00 on the next clock.
- SERVICE behaviour:
  - I_ack without I_enable is ignored.
  - A new NMI edge in the same clock as an NMI ack leaves nmi_pend = 1.
  - An NMI arriving during IRQ service is held and taken at the next poll; there is no hijack.
  - Masking or de-asserting an IRQ after acceptance does not cancel the service.
- Latency: IRQ edge to O_take = 1 is at most (clocks to next poll with I_enable) + 1.

Optional Feature:
- Macro: CORE_INT_VECTOR_TABLE_EN.
- Defined: accepted IRQ gives O_vector = IRQ_TABLE_BASE + 2*O_irq_src (16-bit, wraps mod 2^16).
- Undefined: every IRQ uses IRQ_VECTOR and IRQ_TABLE_BASE is unused.
- NMI, RESET and BRK vectors are identical in both builds.

Decomposition:
- Package core_int_pkg holds:
  - int_kind_type enum (KIND_NONE = 0, KIND_IRQ = 1, KIND_NMI = 2, KIND_RES = 3).
  - Default vector constants.
  - State enum (ST_IDLE, ST_SERVICE).
- Sub-module core_edge_latch: one-bit falling-edge detector with a set-priority clear. Instantiated IRQ_CHANNELS + 1 times (the extra one for NMI).

Test Plan:
- Reset release, I_poll = 1, I_enable pulsed → O_kind = 11, O_vector = FFFC; I_ack → O_take = 0 and a subsequent poll stays IDLE.
- Channel 2 edge-mode, mask = 4'b0100, I_i_flag = 0, I_irq[2] falls → O_take = 1, O_kind = 01, O_irq_src = 2, O_vector = FFFE (FFE4 with CORE_INT_VECTOR_TABLE_EN).
- I_i_flag = 1 with channel 0 level-low → no take; I_i_flag = 0 → taken at the next I_enable & I_poll.
- NMI and IRQ channel 1 pending together → NMI first (FFFA); after ack, IRQ taken at the next poll.
- NMI falling edge in the same clock as the NMI ack → nmi_pend stays 1 and NMI is re-taken at the next poll.
- I_reset asserted during IRQ SERVICE → next clock O_take = 0 and res_pend = 1; the next poll yields RESET.
